// File: rtl/io_responder.sv
// io_responder: memory-mapped IO target for the CPU's LED-write / switch-read strobes.
// Holds the LED register, the synchronised and debounced switches, and a sticky
// button-press flag that clears on read. Read data is combinational from state.
// Optional 7-segment scanner with a read/write SEG register is built when the
// macro SEG7_EN is defined; otherwise offset 0x078 is unmapped.
module io_responder #(
   parameter logic [21:0] IO_BASE         = 22'h3FFFFF,
   parameter int          DEBOUNCE_CYCLES = 20000,
   parameter int          SCAN_CYCLES     = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata_in,
   input  logic        io_write,
   input  logic        io_read,
   output logic [15:0] io_rdata,
   input  logic [15:0] sw_in,
   input  logic        btn_in,
   output logic [15:0] led_out
`ifdef SEG7_EN
   ,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat
`endif
);

   localparam logic [9:0] OFF_LED = 10'h060;
   localparam logic [9:0] OFF_SW  = 10'h070;
   localparam logic [9:0] OFF_BTN = 10'h074;
   localparam logic [9:0] OFF_SEG = 10'h078;

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bus decode
   logic       io_hit;
   logic [9:0] io_off;
   logic       led_we;
   logic       btn_clr;

   assign io_hit  = (io_addr[31:10] == IO_BASE);
   assign io_off  = io_addr[9:0];
   assign led_we  = io_write && io_hit && (io_off == OFF_LED);
   assign btn_clr = io_read && io_hit && (io_off == OFF_BTN);

   // State
   logic [15:0]      led_reg, led_next;
   logic [15:0]      sw_meta_reg, sw_sync_reg;
   logic             btn_meta_reg, btn_sync_reg;
   logic [15:0]      sw_cand_reg, sw_cand_next, sw_stable_reg, sw_stable_next;
   logic [CNT_W-1:0] sw_cnt_reg, sw_cnt_next;
   logic             btn_cand_reg, btn_cand_next, btn_stable_reg, btn_stable_next;
   logic [CNT_W-1:0] btn_cnt_reg, btn_cnt_next;
   logic             btn_flag_reg, btn_flag_next;
   logic             btn_rise;

   // Two-flop synchronisers for the raw pins
   always_ff @(posedge clk) begin
      if (!rst) begin
         sw_meta_reg  <= '0;
         sw_sync_reg  <= '0;
         btn_meta_reg <= 1'b0;
         btn_sync_reg <= 1'b0;
      end else begin
         sw_meta_reg  <= sw_in;
         sw_sync_reg  <= sw_meta_reg;
         btn_meta_reg <= btn_in;
         btn_sync_reg <= btn_meta_reg;
      end
   end

   // Whole-vector switch debounce: any change restarts the stability count
   always_comb begin
      sw_cand_next   = sw_cand_reg;
      sw_cnt_next    = sw_cnt_reg;
      sw_stable_next = sw_stable_reg;
      if (sw_sync_reg != sw_cand_reg) begin
         sw_cand_next = sw_sync_reg;
         sw_cnt_next  = '0;
      end else if (sw_cnt_reg == CNT_MAX) begin
         sw_stable_next = sw_cand_reg;
      end else begin
         sw_cnt_next = sw_cnt_reg + CNT_W'(1);
      end
   end

   // Button debounce, rise detection and sticky flag (a rise beats a clearing read)
   always_comb begin
      btn_cand_next   = btn_cand_reg;
      btn_cnt_next    = btn_cnt_reg;
      btn_stable_next = btn_stable_reg;
      if (btn_sync_reg != btn_cand_reg) begin
         btn_cand_next = btn_sync_reg;
         btn_cnt_next  = '0;
      end else if (btn_cnt_reg == CNT_MAX) begin
         btn_stable_next = btn_cand_reg;
      end else begin
         btn_cnt_next = btn_cnt_reg + CNT_W'(1);
      end
      btn_rise      = btn_stable_next && !btn_stable_reg;
      btn_flag_next = btn_rise || (btn_flag_reg && !btn_clr);
   end

   // LED register load
   always_comb begin
      led_next = led_reg;
      if (led_we) begin
         led_next = io_wdata_in[15:0];
      end
   end

   // Register update for LED, debounce and flag state
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_reg        <= '0;
         sw_cand_reg    <= '0;
         sw_cnt_reg     <= '0;
         sw_stable_reg  <= '0;
         btn_cand_reg   <= 1'b0;
         btn_cnt_reg    <= '0;
         btn_stable_reg <= 1'b0;
         btn_flag_reg   <= 1'b0;
      end else begin
         led_reg        <= led_next;
         sw_cand_reg    <= sw_cand_next;
         sw_cnt_reg     <= sw_cnt_next;
         sw_stable_reg  <= sw_stable_next;
         btn_cand_reg   <= btn_cand_next;
         btn_cnt_reg    <= btn_cnt_next;
         btn_stable_reg <= btn_stable_next;
         btn_flag_reg   <= btn_flag_next;
      end
   end

   assign led_out = led_reg;

`ifdef SEG7_EN
   localparam int                SCAN_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

   logic              seg_we;
   logic [31:0]       seg_reg, seg_next;
   logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
   logic [2:0]        scan_idx_reg, scan_idx_next;
   logic [7:0]        seg_an_reg, seg_an_next, seg_cat_reg, seg_cat_next;
   logic [3:0]        digit_nib [8];

   assign seg_we = io_write && io_hit && (io_off == OFF_SEG);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_digit
         assign digit_nib[gi] = seg_reg[4*gi +: 4];
      end
   endgenerate

   // Active-low hex glyphs, {dp,g,f,e,d,c,b,a}, decimal point always off
   function automatic logic [7:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 8'hC0;
         4'h1: hex_glyph = 8'hF9;
         4'h2: hex_glyph = 8'hA4;
         4'h3: hex_glyph = 8'hB0;
         4'h4: hex_glyph = 8'h99;
         4'h5: hex_glyph = 8'h92;
         4'h6: hex_glyph = 8'h82;
         4'h7: hex_glyph = 8'hF8;
         4'h8: hex_glyph = 8'h80;
         4'h9: hex_glyph = 8'h90;
         4'hA: hex_glyph = 8'h88;
         4'hB: hex_glyph = 8'h83;
         4'hC: hex_glyph = 8'hC6;
         4'hD: hex_glyph = 8'hA1;
         4'hE: hex_glyph = 8'h86;
         default: hex_glyph = 8'h8E;
      endcase
   endfunction

   // Scan timing and registered digit drive for the current index
   always_comb begin
      seg_next      = seg_we ? io_wdata_in : seg_reg;
      seg_an_next   = ~(8'h01 << scan_idx_reg);
      seg_cat_next  = hex_glyph(digit_nib[scan_idx_reg]);
      scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
      scan_idx_next = scan_idx_reg;
      if (scan_cnt_reg == SCAN_MAX) begin
         scan_cnt_next = '0;
         scan_idx_next = scan_idx_reg + 3'd1;
      end
   end

   // Scanner and SEG register update
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_reg      <= '0;
         scan_cnt_reg <= '0;
         scan_idx_reg <= '0;
         seg_an_reg   <= 8'hFF;
         seg_cat_reg  <= 8'hFF;
      end else begin
         seg_reg      <= seg_next;
         scan_cnt_reg <= scan_cnt_next;
         scan_idx_reg <= scan_idx_next;
         seg_an_reg   <= seg_an_next;
         seg_cat_reg  <= seg_cat_next;
      end
   end

   assign seg_an  = seg_an_reg;
   assign seg_cat = seg_cat_reg;
`else
   // Upper store bits and the scan period only matter to the 7-segment option
   logic unused_wdata_hi;
   assign unused_wdata_hi = ^io_wdata_in[31:16];
   localparam int unused_scan_cycles = SCAN_CYCLES;
`endif

   // Combinational read mux; anything not a mapped read returns zero
   always_comb begin
      io_rdata = 16'h0000;
      if (io_read && io_hit) begin
         case (io_off)
            OFF_LED: io_rdata = led_reg;
            OFF_SW:  io_rdata = sw_stable_reg;
            OFF_BTN: io_rdata = {15'b0, btn_flag_reg};
`ifdef SEG7_EN
            OFF_SEG: io_rdata = seg_reg[15:0];
`endif
            default: io_rdata = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder: directed cases with hand-computed values plus a
// randomized run checked every cycle against a behavioural model (run-length
// debounce, cycle-count scan position).
`timescale 1ns/1ps
module tb_io_responder;

   localparam int DEB  = 4;
   localparam int SCAN = 3;

   localparam logic [31:0] A_LED  = 32'hFFFFFC60;
   localparam logic [31:0] A_SW   = 32'hFFFFFC70;
   localparam logic [31:0] A_BTN  = 32'hFFFFFC74;
   localparam logic [31:0] A_SEG  = 32'hFFFFFC78;
   localparam logic [31:0] A_IDLE = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] io_addr;
   logic [31:0] io_wdata_in;
   logic        io_write;
   logic        io_read;
   logic [15:0] io_rdata;
   logic [15:0] sw_in;
   logic        btn_in;
   logic [15:0] led_out;
`ifdef SEG7_EN
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_responder #(
      .IO_BASE(22'h3FFFFF),
      .DEBOUNCE_CYCLES(DEB),
      .SCAN_CYCLES(SCAN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io_addr(io_addr),
      .io_wdata_in(io_wdata_in),
      .io_write(io_write),
      .io_read(io_read),
      .io_rdata(io_rdata),
      .sw_in(sw_in),
      .btn_in(btn_in),
      .led_out(led_out)
`ifdef SEG7_EN
      ,
      .seg_an(seg_an),
      .seg_cat(seg_cat)
`endif
   );

   logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // ---------------- behavioural model ----------------
   bit          model_valid = 1'b0;
   logic [15:0] m_led, m_sw, m_s1, m_s2, m_sw_run_val;
   int          m_sw_run_len;
   logic        m_b1, m_b2, m_btn_run_val, m_btn, m_flag;
   int          m_btn_run_len;
   logic [31:0] m_seg;
   int          m_k;
   logic [7:0]  m_an, m_cat;

   task automatic model_step();
      logic       hit;
      logic [9:0] off;
      logic       old_btn;
      int         j;
      hit = (io_addr[31:10] == 22'h3FFFFF);
      off = io_addr[9:0];
      if (!rst) begin
         m_led = 0; m_sw = 0; m_s1 = 0; m_s2 = 0;
         m_sw_run_val = 0; m_sw_run_len = 1;
         m_b1 = 0; m_b2 = 0; m_btn = 0; m_flag = 0;
         m_btn_run_val = 0; m_btn_run_len = 1;
         m_seg = 0; m_k = 0; m_an = 8'hFF; m_cat = 8'hFF;
         model_valid = 1'b1;
      end else begin
         // a value becomes stable once it has been seen DEB+1 edges in a row
         if (m_s2 == m_sw_run_val) m_sw_run_len++;
         else begin m_sw_run_val = m_s2; m_sw_run_len = 1; end
         if (m_sw_run_len > DEB) m_sw = m_sw_run_val;
         if (m_b2 == m_btn_run_val) m_btn_run_len++;
         else begin m_btn_run_val = m_b2; m_btn_run_len = 1; end
         old_btn = m_btn;
         if (m_btn_run_len > DEB) m_btn = m_btn_run_val;
         m_flag = (m_btn && !old_btn) || (m_flag && !(io_read && hit && off == 10'h074));
         m_s2 = m_s1; m_s1 = sw_in;
         m_b2 = m_b1; m_b1 = btn_in;
         if (io_write && hit && off == 10'h060) m_led = io_wdata_in[15:0];
         j = (m_k / SCAN) % 8;
         m_an  = ~(8'h01 << j);
         m_cat = glyph[m_seg[4*j +: 4]];
         m_k++;
         if (io_write && hit && off == 10'h078) m_seg = io_wdata_in;
      end
   endtask

   function automatic logic [15:0] model_rdata();
      if (!io_read || io_addr[31:10] != 22'h3FFFFF) return 16'h0000;
      case (io_addr[9:0])
         10'h060: return m_led;
         10'h070: return m_sw;
         10'h074: return {15'b0, m_flag};
`ifdef SEG7_EN
         10'h078: return m_seg[15:0];
`endif
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model advances on every rising edge with the inputs the DUT sees
   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Compare process: outputs checked mid-cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (model_valid) begin
            check("cyc_rdata", {16'h0, io_rdata}, {16'h0, model_rdata()});
            check("cyc_led", {16'h0, led_out}, {16'h0, m_led});
`ifdef SEG7_EN
            check("cyc_seg_an", {24'h0, seg_an}, {24'h0, m_an});
            check("cyc_seg_cat", {24'h0, seg_cat}, {24'h0, m_cat});
`endif
         end
      end
   end

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
      @(negedge clk);
      io_addr = a; io_wdata_in = d; io_write = w; io_read = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [21:0] upper;
      logic [9:0]  offs [6];
      logic [7:0]  an_exp;
      int          j;
      offs = '{10'h060, 10'h070, 10'h074, 10'h078, 10'h07C, 10'h074};
      rst = 1'b0; io_addr = 0; io_wdata_in = 0; io_write = 0; io_read = 0;
      sw_in = 0; btn_in = 0;

      // reset state
      repeat (3) bus(A_LED, 0, 0, 1);
      #4 check("rst_led_out", {16'h0, led_out}, 32'h0);
      check("rst_led_read", {16'h0, io_rdata}, 32'h0);
      bus(A_IDLE, 0, 0, 0); rst = 1'b1;
      repeat (8) bus(A_IDLE, 0, 0, 0);

      // LED write then readback
      bus(A_LED, 32'h1234ABCD, 1, 0);
      bus(A_LED, 0, 0, 1);
      #4 check("led_out", {16'h0, led_out}, 32'hABCD);
      check("led_read", {16'h0, io_rdata}, 32'hABCD);

      // switch latency: 0 for 6 cycles, new value from cycle 7
      bus(A_SW, 0, 0, 1); sw_in = 16'h00F0;
      for (int i = 1; i <= 10; i++) begin
         bus(A_SW, 0, 0, 1);
         #4 check("sw_latency", {16'h0, io_rdata}, (i >= 7) ? 32'h00F0 : 32'h0);
      end
      // 2-cycle glitch must not reach the stable value
      bus(A_SW, 0, 0, 1); sw_in = 16'hFFFF;
      bus(A_SW, 0, 0, 1);
      bus(A_SW, 0, 0, 1); sw_in = 16'h00F0;
      for (int i = 0; i < 12; i++) begin
         bus(A_SW, 0, 0, 1);
         #4 check("sw_glitch", {16'h0, io_rdata}, 32'h00F0);
      end

      // button held: one flag, read clears, no re-set while held
      bus(A_IDLE, 0, 0, 0); btn_in = 1'b1;
      repeat (20) bus(A_IDLE, 0, 0, 0);
      bus(A_BTN, 0, 0, 1);
      #4 check("btn_first", {16'h0, io_rdata}, 32'h1);
      bus(A_BTN, 0, 0, 1);
      #4 check("btn_cleared", {16'h0, io_rdata}, 32'h0);
      repeat (10) bus(A_IDLE, 0, 0, 0);
      bus(A_BTN, 0, 0, 1);
      #4 check("btn_held", {16'h0, io_rdata}, 32'h0);
      btn_in = 1'b0;
      repeat (10) bus(A_IDLE, 0, 0, 0);

      // set the flag, release, then clear-read in the very cycle of a new rise
      bus(A_IDLE, 0, 0, 0); btn_in = 1'b1;
      repeat (10) bus(A_IDLE, 0, 0, 0);
      btn_in = 1'b0;
      repeat (10) bus(A_IDLE, 0, 0, 0);
      bus(A_IDLE, 0, 0, 0); btn_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i >= 6) bus(A_BTN, 0, 0, 1);
         else bus(A_IDLE, 0, 0, 0);
         #4 if (i >= 6) check("btn_race", {16'h0, io_rdata}, (i == 8) ? 32'h0 : 32'h1);
      end
      btn_in = 1'b0;
      repeat (10) bus(A_IDLE, 0, 0, 0);

      // decode corners
      bus(32'hFFFFFC7C, 0, 0, 1);
      #4 check("unmapped", {16'h0, io_rdata}, 32'h0);
      bus(32'h12345C60, 0, 0, 1);
      #4 check("miss", {16'h0, io_rdata}, 32'h0);
      bus(A_LED, 0, 0, 0);
      #4 check("no_read", {16'h0, io_rdata}, 32'h0);
      bus(A_SW, 32'h55555555, 1, 0);
      bus(A_LED, 0, 0, 1);
      #4 check("w070_led", {16'h0, led_out}, 32'hABCD);
      bus(A_SW, 0, 0, 1);
      #4 check("w070_sw", {16'h0, io_rdata}, 32'h00F0);
      bus(A_LED, 32'h00005A5A, 1, 1);
      #4 check("rw_pre_edge", {16'h0, io_rdata}, 32'hABCD);
      bus(A_LED, 0, 0, 1);
      #4 check("rw_written", {16'h0, io_rdata}, 32'h5A5A);
      bus(A_SEG, 32'hDEADBEEF, 1, 0);
      bus(A_SEG, 0, 0, 1);
`ifdef SEG7_EN
      #4 check("seg_read", {16'h0, io_rdata}, 32'hBEEF);
`else
      #4 check("seg_unmapped", {16'h0, io_rdata}, 32'h0);
`endif
      bus(A_LED, 0, 0, 1);
      #4 check("led_after_seg", {16'h0, io_rdata}, 32'h5A5A);

      // reset mid-debounce discards the pending value
      bus(A_IDLE, 0, 0, 0); sw_in = 16'h0F0F;
      repeat (3) bus(A_IDLE, 0, 0, 0);
      bus(A_LED, 0, 0, 1); rst = 1'b0;
      bus(A_SW, 0, 0, 1);
      #4 check("rst_mid_led", {16'h0, led_out}, 32'h0);
      check("rst_mid_sw", {16'h0, io_rdata}, 32'h0);
      bus(A_SW, 0, 0, 1); rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bus(A_SW, 0, 0, 1);
         #4 check("rst_sw_latency", {16'h0, io_rdata}, (i >= 7) ? 32'h0F0F : 32'h0);
      end

`ifdef SEG7_EN
      // digit walk after reset: FE/C0 x3, FD/F9 x3, ... 7F/F8, then back to FE
      bus(A_IDLE, 0, 0, 0); rst = 1'b0;
      bus(A_SEG, 32'h76543210, 1, 0); rst = 1'b1;
      for (int i = 1; i <= 27; i++) begin
         bus(A_IDLE, 0, 0, 0);
         j = ((i - 1) / SCAN) % 8;
         an_exp = ~(8'h01 << j);
         #4 check("seg_walk_an", {24'h0, seg_an}, {24'h0, an_exp});
         check("seg_walk_cat", {24'h0, seg_cat}, {24'h0, glyph[j]});
         if (i == 1) check("seg_first", {16'h0, seg_an, seg_cat}, 32'h0000FEC0);
         if (i == 4) check("seg_second", {16'h0, seg_an, seg_cat}, 32'h0000FDF9);
      end
`endif

      // randomized traffic checked by the compare process
      for (int n = 0; n < 1500; n++) begin
         upper = ($urandom_range(0, 7) == 0) ? 22'($urandom) : 22'h3FFFFF;
         bus({upper, offs[$urandom_range(0, 5)]}, $urandom,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
         rst = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 9) == 0)
            sw_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (sw_in ^ (16'h1 << $urandom_range(0, 15)));
         if ($urandom_range(0, 6) == 0) btn_in = ~btn_in;
      end
      bus(A_IDLE, 0, 0, 0);
      #4;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped IO responder on the CPU's IO bus: the target side of the LED-write and switch-read strobes.
- Owns the LED output register, synchronised and debounced switch inputs, and a sticky button-press flag that clears on read.
- Sits between the CPU top and the board pins, sharing the CPU's divided clock.
- Read data is combinational from registered state so the single-cycle CPU can use it in the same cycle. All state changes on the rising clk edge.

Parameters:
- IO_BASE, 22'h3FFFFF: required value of io_addr[31:10] for any IO hit.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles before a debounced value updates. Minimum 2.
- SCAN_CYCLES, 50000: cycles per digit in the 7-segment scan. Used only with SEG7_EN.

Ports:
- clk, input, 1: CPU (divided) clock.
- rst, input, 1: synchronous, active-low reset.
- io_addr, input, 32: byte address from the CPU.
- io_wdata_in, input, 32: CPU store data.
- io_write, input, 1: IO write strobe (LEDCtrl).
- io_read, input, 1: IO read strobe (SwitchCtrl).
- io_rdata, output, 16: read data to the CPU.
- sw_in, input, 16: raw asynchronous switches.
- btn_in, input, 1: raw asynchronous push button.
- led_out, output, 16: LED drive.
- seg_an, output, 8: digit enables, active-low. Present only with SEG7_EN.
- seg_cat, output, 8: segments {dp,g,f,e,d,c,b,a}, active-low. Present only with SEG7_EN.

Behaviour:
- Hit condition: io_addr[31:10]==IO_BASE. Offset is io_addr[9:0].
- Register map:
  - 0x060 LED: read/write.
  - 0x070 SW: read-only, debounced switches.
  - 0x074 BTN: read-only, returns {15'b0, btn_flag}; reading it clears the flag.
  - 0x078 SEG: read/write. Present only with SEG7_EN.
- Write: io_write=1 on a hit to 0x060 loads led_reg <= io_wdata_in[15:0] at the clock edge. led_out=led_reg. Writes to any other offset, or misses, are ignored.
- Read: io_rdata is combinational.
  - Returns the selected register when io_read=1 and the access hits a mapped offset.
  - Returns 16'h0000 otherwise, including on unmapped offsets, misses, and io_read=0.
- io_read and io_write both 1: the write is performed. io_rdata shows the pre-edge value.
- Synchronisers: 2-flop synchroniser on sw_in (16 bits) and on btn_in. No logic reads the raw pins.
- Switch debounce runs on the whole 16-bit vector:
  - sw_sync != sw_cand: sw_cand <= sw_sync, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sw_stable <= sw_cand, cnt holds.
  - Else cnt <= cnt+1.
  - cnt width is $clog2(DEBOUNCE_CYCLES). The counter must not wrap.
- Button debounce: identical scheme, producing btn_stable.
  - A rise edge is btn_stable changing 0 to 1; it sets btn_flag.
  - Holding the button sets the flag only once. A second edge while the flag is set has no extra effect.
- BTN read-to-clear: io_read=1 on a hit to 0x074 clears btn_flag at the edge, and io_rdata shows the pre-clear value.
  - A rise edge in the same cycle as the clearing read wins: the flag stays 1.
- Latency from a pin change to a visible SW value: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycles. A glitch shorter than DEBOUNCE_CYCLES never reaches sw_stable.
- Reset (rst==0 at an edge) clears everything regardless of other inputs: led_reg, sw_cand, sw_stable, both counters, btn_stable, btn_flag and the sync flops all go to 0.
  - Reset mid-debounce discards the pending value.

Optional Feature:
- Macro: SEG7_EN.
- Defined:
  - 32-bit seg_reg at 0x078. A write loads io_wdata_in[31:0]; a read returns seg_reg[15:0].
  - Scan counter advances digit index 0..7, wrapping 7 to 0, every SCAN_CYCLES cycles.
  - seg_an is active-low one-hot on the current index; seg_cat shows the hex glyph of seg_reg[4*idx+3:4*idx]; dp is always off (1).
  - Outputs are registered. Reset gives seg_reg=0, idx=0, seg_an=8'hFF, seg_cat=8'hFF.
  - The first scan output appears on the edge after reset is released.
- Undefined: no seg ports and no seg logic; offset 0x078 behaves as unmapped (reads 0, writes ignored).

Test Plan (DEBOUNCE_CYCLES=4, SCAN_CYCLES=3):
- Reset, then write 0xFFFFFC60 with 32'h1234ABCD -> led_out=16'hABCD next cycle. A later read of 0x060 returns 16'hABCD.
- sw_in steps to 16'h00F0 and holds -> SW read stays 0 for 6 cycles, then returns 16'h00F0 from cycle 7. A 2-cycle pulse to 16'hFFFF leaves the read at 16'h00F0.
- btn_in held 1 for 20 cycles -> BTN read returns 1, the next read returns 0, and the flag is not re-set while the button stays held.
- Clearing BTN read in the same cycle as btn_stable rises -> next BTN read returns 1.
- Read of 0xFFFFFC7C, a read with io_addr[31:10]!=IO_BASE, and any access with io_read=0 -> io_rdata=16'h0000. Write to 0x070 -> LED and SW unchanged. rst=0 mid-debounce -> all state 0, led_out=0.
- With SEG7_EN: write 0x078 with 32'h76543210 -> seg_an walks FE, FD, ..., 7F every 3 cycles, seg_cat shows digits 0..7 (digit 0 = 8'hC0, digit 1 = 8'hF9), then wraps back to FE.
